// File: rtl/core_seq.sv
// Tile instruction sequencer for core: weight load, activation execute,
// and OFIFO drain into psumMem over the 34-bit inst bus.
module core_seq #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int tmo     = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] cfg_w_base,
  input  logic [addr_bw-1:0] cfg_x_base,
  input  logic [addr_bw-1:0] cfg_p_base,
  input  logic [addr_bw-1:0] cfg_len,
  input  logic               cfg_acc,
  input  logic               valid,
  output logic [33:0]        inst,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CW = addr_bw + 1;
  localparam int TW = $clog2(tmo + 1);
  localparam logic [CW-1:0] C_COL = CW'(col);
  localparam logic [CW-1:0] C_RC  = CW'(row + col);
  localparam logic [TW-1:0] C_TMO = TW'(tmo);
  localparam logic [33:0]   IDLE_W = 34'h1_800C_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_WRD, S_WLD, S_WDRN,
    S_XRD, S_XEX, S_PSUM, S_DONE
  } state_t;

  state_t             r_state, w_state;
  logic [CW-1:0]      r_i, w_i;
  logic [CW-1:0]      r_k, w_k;
  logic [CW-1:0]      r_rd, w_rd_cnt;
  logic               r_pend, w_pend;
  logic [TW-1:0]      r_idle, w_idle;
  logic [addr_bw-1:0] r_wb, r_xb, r_pb, r_len;
  logic               r_acc;
  logic               w_err, w_rd, w_wr;
  logic [CW-1:0]      w_len;
  logic [addr_bw-1:0] w_wb;
  logic [33:0]        w_inst;

  assign w_len = {1'b0, r_len};
  assign w_wb  = (r_state == S_IDLE) ? cfg_w_base : r_wb;

  always_comb begin
    w_state  = r_state;
    w_i      = r_i;
    w_k      = r_k;
    w_rd_cnt = r_rd;
    w_pend   = 1'b0;
    w_idle   = r_idle;
    w_err    = err;
    w_rd     = 1'b0;
    w_wr     = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) begin
        w_err   = 1'b0;
        w_i     = '0;
        w_state = (cfg_len == '0) ? S_DONE : S_WRD;
      end
      S_WRD: if (r_i == C_COL) begin
        w_state = S_WLD;
        w_i     = '0;
      end else w_i = r_i + CW'(1);
      S_WLD: if (r_i == C_COL - CW'(1)) begin
        w_state = S_WDRN;
        w_i     = '0;
      end else w_i = r_i + CW'(1);
      S_WDRN: if (r_i == C_RC - CW'(1)) begin
        w_state = S_XRD;
        w_i     = '0;
      end else w_i = r_i + CW'(1);
      S_XRD: if (r_i == w_len) begin
        w_state = S_XEX;
        w_i     = '0;
      end else w_i = r_i + CW'(1);
      S_XEX: if (r_i == w_len - CW'(1)) begin
        w_state  = S_PSUM;
        w_i      = '0;
        w_k      = '0;
        w_rd_cnt = '0;
        w_idle   = '0;
      end else w_i = r_i + CW'(1);
      S_PSUM: if (r_k == w_len) begin
        w_state = S_DONE;
      end else begin
        // r_pend marks an ofifo_rd issued last cycle; its write goes now
        w_rd     = valid && (r_rd < w_len);
        w_wr     = r_pend;
        w_pend   = w_rd;
        w_rd_cnt = r_rd + {{(CW-1){1'b0}}, w_rd};
        w_k      = r_k + {{(CW-1){1'b0}}, w_wr};
        if (valid) begin
          w_idle = '0;
        end else if (r_idle == C_TMO - TW'(1)) begin
          w_err   = 1'b1;
          w_state = S_DONE;
        end else begin
          w_idle = r_idle + TW'(1);
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  // Decode the word for the cycle being entered
  always_comb begin
    w_inst = IDLE_W;
    unique case (w_state)
      S_WRD: begin
        if (w_i < C_COL) begin
          w_inst[19]   = 1'b0;
          w_inst[17:7] = w_wb + w_i[addr_bw-1:0];
        end
        w_inst[2] = (w_i != '0);
      end
      S_WLD: begin
        w_inst[3] = 1'b1;
        w_inst[0] = 1'b1;
      end
      S_XRD: begin
        if (w_i < w_len) begin
          w_inst[19]   = 1'b0;
          w_inst[17:7] = r_xb + w_i[addr_bw-1:0];
        end
        w_inst[2] = (w_i != '0);
      end
      S_XEX: begin
        w_inst[3] = 1'b1;
        w_inst[1] = 1'b1;
      end
      S_PSUM: begin
        w_inst[33] = r_acc;
        w_inst[6]  = w_rd;
        if (w_wr) begin
          w_inst[32]    = 1'b0;
          w_inst[31]    = 1'b0;
          w_inst[30:20] = r_pb + r_k[addr_bw-1:0];
        end
      end
      default: w_inst = IDLE_W;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_k     <= '0;
      r_rd    <= '0;
      r_pend  <= 1'b0;
      r_idle  <= '0;
      r_wb    <= '0;
      r_xb    <= '0;
      r_pb    <= '0;
      r_len   <= '0;
      r_acc   <= 1'b0;
      inst    <= IDLE_W;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      r_state <= w_state;
      r_i     <= w_i;
      r_k     <= w_k;
      r_rd    <= w_rd_cnt;
      r_pend  <= w_pend;
      r_idle  <= w_idle;
      if (r_state == S_IDLE && start) begin
        r_wb  <= cfg_w_base;
        r_xb  <= cfg_x_base;
        r_pb  <= cfg_p_base;
        r_len <= cfg_len;
        r_acc <= cfg_acc;
      end
      inst <= w_inst;
      busy <= (w_state != S_IDLE);
      done <= (w_state == S_DONE);
      err  <= w_err;
    end
  end

endmodule
